// File: rtl/zc_srs_pkg.sv
// Shared types for the SRS ZC sequencing controller: FSM states, status codes, port defaults.
// No logic; imported by the scheduler and its port picker.
// No flow control of its own.
package zc_srs_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int PW_DEF        = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_CNT = 2'd1,
        ST_TMO = 2'd2,
        ST_ABT = 2'd3
    } status_t;

endpackage

// File: rtl/zc_port_pick.sv
// Finds the lowest set mask bit (first=1) or the lowest set bit strictly above ptr (first=0).
// Combinational, zero latency.
// No flow control.
module zc_port_pick
    import zc_srs_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PW        = PW_DEF
) (
    input  logic [NUM_PORTS-1:0] mask,
    input  logic [PW-1:0]        ptr,
    input  logic                 first,
    output logic [PW-1:0]        idx,
    output logic                 found
);

    // Scan downwards so the lowest qualifying bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(ptr)))) begin
                idx   = PW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zc_srs_sched.sv
// Runs the ZC phase engine once per enabled port in ascending order and tags its samples.
// trig->eng_start 2 cycles nominal; samples re-registered with 1-cycle latency.
// eng_start waits for eng_busy low; no backpressure on the sample path.
module zc_srs_sched
    import zc_srs_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PW        = PW_DEF,
    parameter int TIMEOUT   = 4095
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trig,
    input  logic                   abort,
    input  logic [10:0]            cfg_n_zc,
    input  logic [10:0]            cfg_m_sc,
    input  logic [4:0]             cfg_u,
    input  logic                   cfg_v,
    input  logic                   cfg_ktc,
    input  logic [14:0]            cfg_a,
    input  logic [13:0]            cfg_b,
    input  logic [NUM_PORTS-1:0]   cfg_port_mask,
    input  logic [4*NUM_PORTS-1:0] cfg_alpha_tab,
    output logic                   eng_start,
    output logic [3:0]             eng_alpha_p,
    output logic [10:0]            eng_n_zc,
    output logic [10:0]            eng_m_sc,
    output logic [4:0]             eng_u,
    output logic                   eng_v,
    output logic                   eng_ktc,
    output logic [14:0]            eng_a,
    output logic [13:0]            eng_b,
    input  logic                   eng_busy,
    input  logic                   eng_done,
    input  logic                   eng_phi_en,
    input  logic [11:0]            eng_phi_val,
    output logic                   phi_vld,
    output logic [11:0]            phi_val,
    output logic [PW-1:0]          phi_port,
    output logic [10:0]            phi_idx,
    output logic                   sched_busy,
    output logic                   sched_done,
    output logic [1:0]             sched_status
);

    localparam int             TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  T_MAX  = {TW{1'b1}};

    state_t                   state_q, state_d;
    status_t                  status_q, status_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]     mask_q;
    logic [4*NUM_PORTS-1:0]   alpha_q;
    logic [10:0]              smp_cnt;
    logic [10:0]              cnt_final;
    logic [TW-1:0]            timer;
    logic                     abort_seen;
    logic                     latch_cfg;
    logic                     in_run;
    logic                     pick_first;
    logic [NUM_PORTS-1:0]     pick_mask;
    logic [PW-1:0]            pick_idx;
    logic                     pick_found;

    assign pick_first = (state_q == IDLE);
    assign pick_mask  = pick_first ? cfg_port_mask : mask_q;

    zc_port_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_pick (
        .mask  (pick_mask),
        .ptr   (ptr_q),
        .first (pick_first),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign in_run       = (state_q == RUN) || (state_q == DRAIN);
    assign cnt_final    = smp_cnt + 11'(eng_phi_en);
    assign eng_alpha_p  = alpha_q[{ptr_q, 2'b00} +: 4];
    assign sched_status = status_q;

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        ptr_d      = ptr_q;
        latch_cfg  = 1'b0;
        eng_start  = 1'b0;
        sched_done = 1'b0;
        sched_busy = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (trig && !abort) begin
                    latch_cfg = 1'b1;
                    status_d  = ST_OK;
                    ptr_d     = pick_idx;
                    state_d   = pick_found ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = DONE;
                    if (status_q == ST_OK) status_d = ST_ABT;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                if (abort) begin
                    state_d = DONE;
                    if (status_q == ST_OK) status_d = ST_ABT;
                end else if (!eng_busy) begin
                    eng_start = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (eng_done) begin
                    if ((status_q == ST_OK) && (cnt_final != eng_m_sc)) status_d = ST_CNT;
                    if (abort_seen || abort) begin
                        state_d = DONE;
                        if (status_d == ST_OK) status_d = ST_ABT;
                    end else if (pick_found) begin
                        ptr_d   = pick_idx;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (timer == T_LAST) begin
                    if (status_q == ST_OK) status_d = ST_TMO;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!eng_busy) state_d = DONE;
            end
            DONE: begin
                // A sample still leaving the tag register pushes the done pulse out one cycle.
                if (!phi_vld) begin
                    sched_done = 1'b1;
                    sched_busy = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            status_q   <= ST_OK;
            ptr_q      <= '0;
            mask_q     <= '0;
            alpha_q    <= '0;
            smp_cnt    <= '0;
            timer      <= '0;
            abort_seen <= 1'b0;
            eng_n_zc   <= '0;
            eng_m_sc   <= '0;
            eng_u      <= '0;
            eng_v      <= 1'b0;
            eng_ktc    <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
            phi_vld    <= 1'b0;
            phi_val    <= '0;
            phi_port   <= '0;
            phi_idx    <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            ptr_q    <= ptr_d;
            if (latch_cfg) begin
                mask_q   <= cfg_port_mask;
                alpha_q  <= cfg_alpha_tab;
                eng_n_zc <= cfg_n_zc;
                eng_m_sc <= cfg_m_sc;
                eng_u    <= cfg_u;
                eng_v    <= cfg_v;
                eng_ktc  <= cfg_ktc;
                eng_a    <= cfg_a;
                eng_b    <= cfg_b;
            end
            if (eng_start) begin
                smp_cnt    <= '0;
                timer      <= '0;
                abort_seen <= 1'b0;
            end else if (in_run) begin
                if (eng_phi_en) smp_cnt <= smp_cnt + 11'd1;
                if (timer != T_MAX) timer <= timer + TW'(1);
                if (abort) abort_seen <= 1'b1;
            end
            phi_vld <= eng_phi_en && in_run;
            if (eng_phi_en) begin
                phi_val  <= eng_phi_val;
                phi_idx  <= smp_cnt;
                phi_port <= ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_zc_srs_sched.sv
// Directed bench for zc_srs_sched: behavioural engine, sequence model and per-cycle compare.
module tb_zc_srs_sched;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst, trig, abort;
    logic [10:0] cfg_n_zc, cfg_m_sc;
    logic [4:0]  cfg_u;
    logic        cfg_v, cfg_ktc;
    logic [14:0] cfg_a;
    logic [13:0] cfg_b;
    logic [3:0]  cfg_port_mask;
    logic [15:0] cfg_alpha_tab;
    logic        eng_start;
    logic [3:0]  eng_alpha_p;
    logic [10:0] eng_n_zc, eng_m_sc;
    logic [4:0]  eng_u;
    logic        eng_v, eng_ktc;
    logic [14:0] eng_a;
    logic [13:0] eng_b;
    logic        eng_busy, eng_done, eng_phi_en;
    logic [11:0] eng_phi_val;
    logic        phi_vld;
    logic [11:0] phi_val;
    logic [1:0]  phi_port;
    logic [10:0] phi_idx;
    logic        sched_busy, sched_done;
    logic [1:0]  sched_status;

    always #5 clk = ~clk;

    zc_srs_sched #(.NUM_PORTS(4), .PW(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort),
        .cfg_n_zc(cfg_n_zc), .cfg_m_sc(cfg_m_sc), .cfg_u(cfg_u), .cfg_v(cfg_v),
        .cfg_ktc(cfg_ktc), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_port_mask(cfg_port_mask), .cfg_alpha_tab(cfg_alpha_tab),
        .eng_start(eng_start), .eng_alpha_p(eng_alpha_p),
        .eng_n_zc(eng_n_zc), .eng_m_sc(eng_m_sc), .eng_u(eng_u), .eng_v(eng_v),
        .eng_ktc(eng_ktc), .eng_a(eng_a), .eng_b(eng_b),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_phi_en(eng_phi_en),
        .eng_phi_val(eng_phi_val),
        .phi_vld(phi_vld), .phi_val(phi_val), .phi_port(phi_port), .phi_idx(phi_idx),
        .sched_busy(sched_busy), .sched_done(sched_done), .sched_status(sched_status)
    );

    int errors = 0;
    int checks = 0;

    // sequence model state
    int          port_list[$];
    logic [15:0] alpha_cfg;
    int          exp_status;
    int          start_base;
    int          alpha_seen[$];
    int          cyc = 0;
    int          n_start = 0, n_phi = 0, n_done = 0;
    int          done_cyc = 0, last_phi_cyc = -1, trig_cyc = 0;

    // engine model knobs
    int          nsmp[4];
    int          eng_run;
    bit          hang = 0;
    int          hang_smp_k, hang_len;
    bit          busy_on_trig = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input logic [3:0] mask, input logic [15:0] atab, input int msc);
        cfg_port_mask = mask;
        cfg_alpha_tab = atab;
        cfg_m_sc      = 11'(msc);
        cfg_n_zc      = 11'd139;
        cfg_u         = 5'd7;
        cfg_v         = 1'b1;
        cfg_ktc       = 1'b0;
        cfg_a         = 15'h1234;
        cfg_b         = 14'h0abc;
        alpha_cfg     = atab;
        port_list.delete();
        for (int p = 0; p < 4; p++) if (mask[p]) port_list.push_back(p);
        start_base = n_start;
        eng_run    = 0;
        alpha_seen.delete();
    endtask

    task automatic pulse_trig(input logic ab);
        @(negedge clk); trig = 1'b1; abort = ab; #3; trig_cyc = cyc;
        @(negedge clk); trig = 1'b0; abort = 1'b0; #3;
    endtask

    task automatic wait_start(input int budget, output int c);
        int i;
        i = 0;
        while (n_start == start_base && i < budget) begin @(negedge clk); #3; i++; end
        chk("start_seen", n_start != start_base, 1);
        c = (n_start != start_base) ? cyc : -1;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (n_done == d0 && i < budget) begin @(negedge clk); #3; i++; end
        chk("done_seen", n_done != d0, 1);
    endtask

    // behavioural engine: busy from start, n samples, then a done pulse
    initial begin : engine
        int k, n_target;
        bit active;
        int pre_busy;
        active = 0; pre_busy = 0; k = 0; n_target = 0;
        eng_busy = 0; eng_done = 0; eng_phi_en = 0; eng_phi_val = '0;
        forever begin
            @(negedge clk);
            eng_phi_en = 1'b0;
            eng_done   = 1'b0;
            if (rst) begin
                active = 0; pre_busy = 0; eng_busy = 1'b0;
            end else if (pre_busy > 0) begin
                eng_busy = 1'b1; pre_busy--;
            end else if (active) begin
                eng_busy = 1'b1;
                if (k < n_target) begin
                    eng_phi_en = 1'b1; eng_phi_val = 12'($urandom);
                end else if (hang) begin
                    if (k == hang_smp_k) begin eng_phi_en = 1'b1; eng_phi_val = 12'($urandom); end
                    if (k >= hang_len) begin active = 0; eng_busy = 1'b0; end
                end else begin
                    eng_done = 1'b1; active = 0;
                end
                k++;
            end else begin
                eng_busy = 1'b0;
            end
            #1;
            if (busy_on_trig && trig) pre_busy = 5;
            if (eng_start) begin
                active = 1; k = 0; n_target = nsmp[eng_run % 4]; eng_run++;
            end
        end
    end

    // compare process: tagged samples, start order/alpha, end status
    initial begin : compare
        bit          pend_vld;
        logic [11:0] pend_val;
        int          pend_port, pend_idx, cur_port, smp_since, p;
        pend_vld = 0; pend_val = '0; pend_port = 0; pend_idx = 0; cur_port = 0; smp_since = 0;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!rst) begin
                if (pend_vld || phi_vld) begin
                    chk("phi_vld", phi_vld, pend_vld);
                    if (pend_vld && phi_vld) begin
                        chk("phi_val", phi_val, pend_val);
                        chk("phi_port", phi_port, pend_port);
                        chk("phi_idx", phi_idx, pend_idx);
                    end
                end
                if (phi_vld) begin n_phi++; last_phi_cyc = cyc; end
                if (eng_start) begin
                    chk("start_busy", eng_busy, 0);
                    if (n_start - start_base < port_list.size()) begin
                        p = port_list[n_start - start_base];
                        chk("start_alpha", eng_alpha_p, alpha_cfg[p*4 +: 4]);
                        cur_port = p;
                    end else begin
                        chk("start_count", n_start - start_base, port_list.size() - 1);
                    end
                    alpha_seen.push_back(int'(eng_alpha_p));
                    n_start++;
                    smp_since = 0;
                end
                if (sched_done) begin
                    chk("done_status", sched_status, exp_status);
                    chk("done_after_phi", last_phi_cyc < cyc, 1);
                    n_done++;
                    done_cyc = cyc;
                end
                pend_vld  = eng_phi_en;
                pend_val  = eng_phi_val;
                pend_port = cur_port;
                pend_idx  = smp_since;
                if (eng_phi_en) smp_since++;
            end else begin
                pend_vld = 0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0, d0, p0, c_start;
        rst = 1'b1; trig = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) nsmp[i] = 144;
        set_cfg(4'b1111, 16'hffff, 100);
        repeat (3) @(negedge clk);
        #3;
        chk("rst_eng_start", eng_start, 0);
        chk("rst_sched_busy", sched_busy, 0);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_status", sched_status, 0);
        chk("rst_phi_vld", phi_vld, 0);
        chk("rst_alpha", eng_alpha_p, 0);
        chk("rst_n_zc", eng_n_zc, 0);
        chk("rst_m_sc", eng_m_sc, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: three ports, ideal engine
        set_cfg(4'b1011, {4'd6, 4'd0, 4'd3, 4'd1}, 144);
        exp_status = 0; d0 = n_done; p0 = n_phi;
        pulse_trig(1'b0);
        chk("t1_busy", sched_busy, 1);
        wait_start(20, c_start);
        chk("t1_start_lat", c_start - trig_cyc, 2);
        wait_done(d0, 1000);
        chk("t1_starts", n_start - start_base, 3);
        chk("t1_phi_cnt", n_phi - p0, 432);
        chk("t1_alpha_n", alpha_seen.size(), 3);
        if (alpha_seen.size() == 3) begin
            chk("t1_alpha0", alpha_seen[0], 1);
            chk("t1_alpha1", alpha_seen[1], 3);
            chk("t1_alpha2", alpha_seen[2], 6);
        end
        chk("t1_n_zc", eng_n_zc, 139);
        chk("t1_m_sc", eng_m_sc, 144);
        chk("t1_busy_end", sched_busy, 0);
        repeat (3) @(negedge clk);

        // 2: empty mask
        set_cfg(4'b0000, 16'h4321, 144);
        exp_status = 0; d0 = n_done;
        pulse_trig(1'b0);
        wait_done(d0, 10);
        chk("t2_done_lat", done_cyc - trig_cyc, 1);
        chk("t2_starts", n_start - start_base, 0);
        repeat (3) @(negedge clk);

        // 3: port 0 short by one sample
        set_cfg(4'b0101, 16'h0905, 144);
        nsmp[0] = 143;
        exp_status = 1; d0 = n_done; p0 = n_phi;
        pulse_trig(1'b0);
        wait_done(d0, 1000);
        chk("t3_starts", n_start - start_base, 2);
        chk("t3_phi_cnt", n_phi - p0, 287);
        nsmp[0] = 144;
        repeat (3) @(negedge clk);

        // 4: engine never finishes
        set_cfg(4'b0011, 16'h0072, 144);
        nsmp[0] = 10; hang = 1; hang_smp_k = TMO + 5; hang_len = TMO + 20;
        exp_status = 2; d0 = n_done; p0 = n_phi;
        pulse_trig(1'b0);
        wait_start(20, c_start);
        wait_done(d0, 600);
        chk("t4_starts", n_start - start_base, 1);
        chk("t4_phi_cnt", n_phi - p0, 11);
        chk("t4_done_time", done_cyc - c_start, TMO + 22);
        hang = 0; nsmp[0] = 144;
        repeat (3) @(negedge clk);

        // 5: abort during port 0, then trig with abort in IDLE
        set_cfg(4'b0011, 16'h0084, 20);
        for (int i = 0; i < 4; i++) nsmp[i] = 20;
        exp_status = 3; d0 = n_done; p0 = n_phi;
        pulse_trig(1'b0);
        wait_start(20, c_start);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_done(d0, 200);
        chk("t5_starts", n_start - start_base, 1);
        chk("t5_phi_cnt", n_phi - p0, 20);
        s0 = n_start; d0 = n_done;
        pulse_trig(1'b1);
        chk("t5_ign_busy", sched_busy, 0);
        repeat (10) @(negedge clk);
        #3;
        chk("t5_ign_starts", n_start, s0);
        chk("t5_ign_done", n_done, d0);
        chk("t5_ign_status", sched_status, 3);

        // 6: engine busy on entry, cfg changed mid-sequence
        set_cfg(4'b0010, 16'h00d0, 30);
        for (int i = 0; i < 4; i++) nsmp[i] = 30;
        busy_on_trig = 1;
        exp_status = 0; d0 = n_done;
        pulse_trig(1'b0);
        @(negedge clk);
        cfg_n_zc = 11'd500; cfg_m_sc = 11'd7; cfg_u = 5'd3; cfg_v = 1'b0;
        cfg_ktc = 1'b1; cfg_a = 15'h0001; cfg_b = 14'h0002;
        cfg_port_mask = 4'hf; cfg_alpha_tab = 16'hffff;
        #3;
        wait_start(20, c_start);
        chk("t6_start_lat", c_start - trig_cyc, 6);
        wait_done(d0, 200);
        busy_on_trig = 0;
        chk("t6_starts", n_start - start_base, 1);
        chk("t6_n_zc", eng_n_zc, 139);
        chk("t6_m_sc", eng_m_sc, 30);
        chk("t6_u", eng_u, 7);
        chk("t6_ktc", eng_ktc, 0);
        chk("t6_a", eng_a, 15'h1234);
        chk("t6_b", eng_b, 14'h0abc);
        chk("t6_alpha", eng_alpha_p, 13);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
